// File: rtl/nios_led3_pkg.sv
// Shared definitions for the button-to-LED interrupt servicer and its PIO slave.
package nios_led3_pkg;

    localparam int unsigned BTN_W_DEF = 2;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 2;

    // PIO register map
    localparam logic [ADDR_W-1:0] PIO_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] PIO_MASK = 2'd2;
    localparam logic [ADDR_W-1:0] PIO_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_CLEAR,
        ST_UPDATE,
        ST_HOLDOFF
    } state_e;

endpackage

// File: rtl/nios_led3_holdoff_timer.sv
// Debounce hold-off down-counter: load sets CYC-1, count decrements to zero, done_c flags zero.
module nios_led3_holdoff_timer #(
    parameter int unsigned CYC = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic count,
    output logic done_c
);

    localparam int unsigned W = (CYC > 0) ? $clog2(CYC + 1) : 1;
    localparam logic [W-1:0] LOAD_VAL = (CYC > 0) ? W'(CYC - 1) : '0;

    logic [W-1:0] cnt;

    // Down-counter; stops at zero so done_c stays high until the next load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (count && !done_c) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/nios_led3_btn_irq_master.sv
// Avalon-MM initiator that services the button PIO interrupt in hardware and toggles LEDs.
module nios_led3_btn_irq_master
    import nios_led3_pkg::*;
#(
    parameter int unsigned      BTN_W       = BTN_W_DEF,
    parameter logic [BTN_W-1:0] MASK_INIT   = '1,
    parameter int unsigned      HOLDOFF_CYC = 50000,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              irq,
    input  logic [DATA_W-1:0] readdata,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    output logic [BTN_W-1:0]  led_out,
    output logic [CNT_W-1:0]  event_count,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [BTN_W-1:0]  cap_q, cap_d;
    logic [ADDR_W-1:0] address_d;
    logic              chipselect_d;
    logic              write_n_d;
    logic [DATA_W-1:0] writedata_d;
    logic [BTN_W-1:0]  led_d;
    logic [CNT_W-1:0]  count_d;
    logic              hold_load_c;
    logic              hold_done_c;
    logic              unused_readdata_c;

    // Only the edge bits of the capture register are meaningful
    assign unused_readdata_c = &{1'b0, readdata[DATA_W-1:BTN_W]};

    nios_led3_holdoff_timer #(
        .CYC (HOLDOFF_CYC)
    ) u_holdoff (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (hold_load_c),
        .count   (state_q == ST_HOLDOFF),
        .done_c  (hold_done_c)
    );

    // State and registered bus/status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            cap_q       <= '0;
            address     <= '0;
            chipselect  <= 1'b0;
            write_n     <= 1'b1;
            writedata   <= '0;
            led_out     <= '0;
            event_count <= '0;
            busy        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            address     <= address_d;
            chipselect  <= chipselect_d;
            write_n     <= write_n_d;
            writedata   <= writedata_d;
            led_out     <= led_d;
            event_count <= count_d;
            busy        <= (state_d != ST_IDLE);
        end
    end

    // Next state; bus fields are decoded for the state being entered so they appear in that state
    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        address_d    = address;
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
        writedata_d  = writedata;
        led_d        = led_out;
        count_d      = event_count;
        hold_load_c  = 1'b0;

        case (state_q)
            ST_INIT: begin
                // First cycle after reset issues the mask write, second cycle moves on
                if (!chipselect) begin
                    chipselect_d = 1'b1;
                    write_n_d    = 1'b0;
                    address_d    = PIO_MASK;
                    writedata_d  = DATA_W'(MASK_INIT);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (irq && enable) begin
                    state_d      = ST_RD_ADDR;
                    chipselect_d = 1'b1;
                    address_d    = PIO_EDGE;
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                cap_d = readdata[BTN_W-1:0];
                if (readdata[BTN_W-1:0] != '0) begin
                    state_d      = ST_CLEAR;
                    chipselect_d = 1'b1;
                    write_n_d    = 1'b0;
                    address_d    = PIO_EDGE;
                    writedata_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                led_d   = led_out ^ cap_q;
                count_d = event_count + CNT_W'(1);
                if (HOLDOFF_CYC == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_HOLDOFF;
                    hold_load_c = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (hold_done_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule
